// File: rtl/adder_rr_scheduler.sv
// ============================================================================
//  Module   : adder_rr_scheduler
//  Function : Round-robin sharing of one external combinational adder between
//             two valid/ready requesters, one operation in flight at a time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_rr_scheduler #(
    parameter int WIDTH     = 16,
    parameter int OP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic             req_cin0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic             req_cin1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_overflow
);

    localparam int c_CNT_W = (OP_CYCLES > 1) ? $clog2(OP_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_add_cin;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_overflow;

    logic               w_accept;
    logic               w_grant;

    // Gated by rst so that ready is low for the whole reset interval.
    always_comb begin
        w_accept = 1'b0;
        w_grant  = 1'b0;
        if ((r_state == c_IDLE) && !rst && (|req_valid)) begin
            w_accept = 1'b1;
            if (&req_valid) begin
                w_grant = ~r_last_grant;
            end else begin
                w_grant = req_valid[1];
            end
        end
    end

    assign req_ready    = {w_accept & w_grant, w_accept & ~w_grant};
    assign rsp_valid    = (r_state == c_RESP) ? {r_grant, ~r_grant} : 2'b00;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_cin      = r_add_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_grant        <= 1'b0;
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_cin      <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_add_a      <= w_grant ? req_a1   : req_a0;
                        r_add_b      <= w_grant ? req_b1   : req_b0;
                        r_add_cin    <= w_grant ? req_cin1 : req_cin0;
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_rsp_result   <= add_result;
                        r_rsp_overflow <= add_overflow;
                        r_state        <= c_RESP;
                    end
                end
                c_RESP: begin
                    // Only the owner of the response can release it.
                    if (rsp_ready[r_grant]) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
// ============================================================================
//  Module   : tb_adder_rr_scheduler
//  Function : Self-checking bench for adder_rr_scheduler with an adder model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic        req_cin0, req_cin1;
    logic [15:0] rsp_result, add_a, add_b, add_result;
    logic        rsp_overflow, add_cin, add_overflow;
    logic [16:0] add_sum;

    int errors = 0;
    int checks = 0;
    bit m_last_grant;

    logic [1:0]  obs_ready, obs_rv;
    logic [15:0] obs_res;
    logic        obs_ovf;
    int          obs_lat;
    bit          obs_stall_ok, obs_to;

    always #5 clk = ~clk;

    // The shared sixteen_bit_adder lives outside the scheduler.
    assign add_sum      = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    assign add_result   = add_sum[15:0];
    assign add_overflow = (add_a[15] == add_b[15]) && (add_result[15] != add_a[15]);

    adder_rr_scheduler #(.WIDTH(16), .OP_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
        .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_result(add_result), .add_overflow(add_overflow)
    );

    function automatic logic [15:0] exp_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
        return a + b + {15'b0, c};
    endfunction

    function automatic logic exp_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic logic exp_grant(input logic [1:0] v);
        if (v == 2'b11) return ~m_last_grant;
        return v[1];
    endfunction

    // Drives one transaction from a negedge; leaves observations in obs_*.
    task automatic run_op(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                          input logic c0, input logic [15:0] a1, input logic [15:0] b1,
                          input logic c1, input int stall);
        int n;
        obs_to = 0; obs_stall_ok = 1; obs_lat = 0; obs_ready = 0; obs_rv = 0;
        obs_res = '0; obs_ovf = 0;
        req_valid = v; req_a0 = a0; req_b0 = b0; req_cin0 = c0;
        req_a1 = a1; req_b1 = b1; req_cin1 = c1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 50) begin @(negedge clk); #1; n++; end
        if (req_ready == 2'b00) begin obs_to = 1; req_valid = 0; return; end
        obs_ready = req_ready;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (rsp_valid == 2'b00 && n < 50);
        obs_lat = n;
        if (rsp_valid == 2'b00) begin obs_to = 1; req_valid = 0; return; end
        obs_rv = rsp_valid; obs_res = rsp_result; obs_ovf = rsp_overflow;
        rsp_ready = ~obs_rv;
        repeat (stall) begin
            @(negedge clk); #1;
            if (rsp_valid !== obs_rv || rsp_result !== obs_res ||
                rsp_overflow !== obs_ovf || req_ready !== 2'b00) obs_stall_ok = 0;
        end
        rsp_ready = obs_rv;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00; req_valid = 2'b00;
    endtask

    task automatic do_reset();
        req_valid = 0; rsp_ready = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_last_grant = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b11; #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_result !== 16'h0 || rsp_overflow !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0000/0", rsp_result, rsp_overflow); end
        checks++; if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin errors++; $display("FAIL reset_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        m_last_grant = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_t1();
        run_op(2'b01, 16'd15, 16'd12, 1'b0, 16'h0, 16'h0, 1'b0, 0);
        m_last_grant = 1'b0;
        checks++; if (obs_to) begin errors++; $display("FAIL t1_timeout got=1 exp=0"); end
        checks++; if (obs_rv !== 2'b01) begin errors++; $display("FAIL t1_rsp_valid got=%b exp=01", obs_rv); end
        checks++; if (obs_res !== 16'd27 || obs_ovf !== 1'b0) begin errors++; $display("FAIL t1_result got=%0d/%b exp=27/0", obs_res, obs_ovf); end
        checks++; if (obs_lat != 2) begin errors++; $display("FAIL t1_latency got=%0d exp=2", obs_lat); end
        checks++; if (add_a !== 16'd15 || add_b !== 16'd12) begin errors++; $display("FAIL t1_add_hold got=%0d/%0d exp=15/12", add_a, add_b); end
    endtask

    task automatic test_t2();
        run_op(2'b10, 16'h0, 16'h0, 1'b0, 16'hFFED, 16'd21, 1'b0, 0);
        m_last_grant = 1'b1;
        checks++; if (obs_ready !== 2'b10) begin errors++; $display("FAIL t2_req_ready got=%b exp=10", obs_ready); end
        checks++; if (obs_rv !== 2'b10) begin errors++; $display("FAIL t2_rsp_valid got=%b exp=10", obs_rv); end
        checks++; if (obs_res !== 16'd2 || obs_ovf !== 1'b0) begin errors++; $display("FAIL t2_result got=%h/%b exp=0002/0", obs_res, obs_ovf); end
    endtask

    task automatic test_t3();
        run_op(2'b01, 16'd32767, 16'd32767, 1'b0, 16'h0, 16'h0, 1'b0, 0);
        m_last_grant = 1'b0;
        checks++; if (obs_res !== 16'hFFFE || obs_ovf !== 1'b1) begin errors++; $display("FAIL t3_overflow got=%h/%b exp=fffe/1", obs_res, obs_ovf); end
        run_op(2'b01, 16'd1923, 16'hE6EB, 1'b0, 16'h0, 16'h0, 1'b0, 0);
        checks++; if (obs_res !== 16'hEE6E || obs_ovf !== 1'b0) begin errors++; $display("FAIL t3_negative got=%h/%b exp=ee6e/0", obs_res, obs_ovf); end
    endtask

    task automatic test_back_to_back();
        logic g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            g = exp_grant(2'b11);
            run_op(2'b11, 16'(100 + i), 16'd1, 1'b0, 16'(200 + i), 16'd2, 1'b1, 0);
            m_last_grant = g;
            checks++; if (obs_ready !== {g, ~g} || obs_rv !== {g, ~g}) begin errors++; $display("FAIL rr_grant op=%0d got=%b/%b exp=%b", i, obs_ready, obs_rv, {g, ~g}); end
            checks++; if (obs_res !== (g ? 16'(203 + i) : 16'(101 + i))) begin errors++; $display("FAIL rr_result op=%0d got=%0d exp=%0d", i, obs_res, g ? 203 + i : 101 + i); end
            if (i == 0) begin
                checks++; if (g !== 1'b0) begin errors++; $display("FAIL rr_model_first got=%b exp=0", g); end
            end
        end
    endtask

    task automatic test_stall();
        logic g;
        g = exp_grant(2'b11);
        run_op(2'b11, 16'h7000, 16'h1000, 1'b1, 16'h8000, 16'h8000, 1'b0, 10);
        m_last_grant = g;
        checks++; if (!obs_stall_ok) begin errors++; $display("FAIL stall_hold got=changed exp=stable"); end
        checks++; if (obs_rv !== {g, ~g}) begin errors++; $display("FAIL stall_rsp_valid got=%b exp=%b", obs_rv, {g, ~g}); end
        checks++; if (obs_res !== (g ? 16'h0000 : 16'h8001) || obs_ovf !== 1'b1) begin errors++; $display("FAIL stall_result got=%h/%b exp=%h/1", obs_res, obs_ovf, g ? 16'h0000 : 16'h8001); end
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [15:0] a0, b0, a1, b1, ea, eb;
        logic        c0, c1, g, ec;
        for (int i = 0; i < 40; i++) begin
            v  = 2'($urandom_range(1, 3));
            a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
            g  = exp_grant(v);
            ea = g ? a1 : a0; eb = g ? b1 : b0; ec = g ? c1 : c0;
            run_op(v, a0, b0, c0, a1, b1, c1, int'($urandom_range(0, 3)));
            m_last_grant = g;
            checks++; if (obs_to || obs_ready !== {g, ~g} || obs_rv !== {g, ~g}) begin errors++; $display("FAIL rand_grant op=%0d got=%b/%b exp=%b", i, obs_ready, obs_rv, {g, ~g}); end
            checks++; if (obs_res !== exp_sum(ea, eb, ec) || obs_ovf !== exp_ovf(ea, eb, ec)) begin errors++; $display("FAIL rand_result op=%0d got=%h/%b exp=%h/%b", i, obs_res, obs_ovf, exp_sum(ea, eb, ec), exp_ovf(ea, eb, ec)); end
            checks++; if (obs_lat != 2 || !obs_stall_ok) begin errors++; $display("FAIL rand_timing op=%0d got=lat%0d/hold%0d exp=lat2/hold1", i, obs_lat, obs_stall_ok); end
        end
    endtask

    task automatic test_rst_exec();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 16'd100; req_b0 = 16'd200; req_cin0 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL rstexec_handshake got=%b/%b exp=00/00", req_ready, rsp_valid); end
        checks++; if (rsp_result !== 16'h0 || rsp_overflow !== 1'b0) begin errors++; $display("FAIL rstexec_rsp got=%h/%b exp=0000/0", rsp_result, rsp_overflow); end
        checks++; if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin errors++; $display("FAIL rstexec_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
        req_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
        m_last_grant = 1'b1;
        run_op(2'b11, 16'd40, 16'd2, 1'b0, 16'd7, 16'd7, 1'b0, 0);
        m_last_grant = 1'b0;
        checks++; if (obs_to || obs_rv !== 2'b01 || obs_res !== 16'd42 || obs_lat != 2) begin errors++; $display("FAIL rstexec_next got=%b/%0d/lat%0d exp=01/42/lat2", obs_rv, obs_res, obs_lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_cin0 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_cin1 = 1'b0;
        m_last_grant = 1'b1;
        test_reset();
        test_t1();
        test_t2();
        test_t3();
        test_back_to_back();
        test_stall();
        test_random();
        test_rst_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
